// File: rtl/acc_mem_pkg.sv
// -----------------------------------------------------------------------------
// acc_mem_pkg
// Shared types and default widths for the accelerator memory arbiter.
//   arb_state_t   : arbiter FSM states
//   DEF_*         : default port widths used as parameter defaults
//   LAT_CNT_W     : width of the read-latency down-counter (latency 1..7)
// -----------------------------------------------------------------------------
package acc_mem_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_RD_DATA_W = 512;
    localparam int DEF_WR_DATA_W = 32;
    localparam int LAT_CNT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2,
        ST_WR_RESP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: returns the first requesting index at or
// after ptr_i, wrapping around.
//   req_i         : request vector
//   ptr_i         : index with highest priority this cycle
//   grant_valid_o : at least one request present
//   grant_oh_o    : one-hot grant
//   grant_idx_o   : encoded grant index
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             grant_valid_o,
    output logic [N-1:0]     grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        sum           = '0;
        idx           = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit so ptr+k can be wrapped without overflow.
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o   = 1'b1;
                grant_idx_o     = idx;
                grant_oh_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// acc_mem_arbiter
// Shares the accelerator-side data-memory port between NUM_ACC accelerators.
// The CPU always wins: accelerator accesses are issued only in IDLE cycles with
// cpu_busy low. Requesters are served round-robin, one transaction at a time.
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu_busy            : CPU owns the memory port this cycle
//   acc_rd_en/_addr     : per-accelerator read request (level) and address
//   acc_wr_en/_addr/_data : per-accelerator write request, address, data
//   acc_rd_valid        : one-cycle read completion pulse per accelerator
//   acc_rd_data         : last captured read line, shared by all accelerators
//   acc_wr_done         : one-cycle write completion pulse per accelerator
//   mem_en/_we/_addr/_wdata : memory request, driven only in the grant cycle
//   mem_rdata           : read line, MEM_RD_LATENCY cycles after mem_en
// -----------------------------------------------------------------------------
module acc_mem_arbiter
    import acc_mem_pkg::*;
#(
    parameter int NUM_ACC        = 2,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int RD_DATA_W      = DEF_RD_DATA_W,
    parameter int WR_DATA_W      = DEF_WR_DATA_W,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cpu_busy,
    input  logic [NUM_ACC-1:0]             acc_rd_en,
    input  logic [NUM_ACC*ADDR_W-1:0]      acc_rd_addr,
    input  logic [NUM_ACC-1:0]             acc_wr_en,
    input  logic [NUM_ACC*ADDR_W-1:0]      acc_wr_addr,
    input  logic [NUM_ACC*WR_DATA_W-1:0]   acc_wr_data,
    output logic [NUM_ACC-1:0]             acc_rd_valid,
    output logic [RD_DATA_W-1:0]           acc_rd_data,
    output logic [NUM_ACC-1:0]             acc_wr_done,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [WR_DATA_W-1:0]           mem_wdata,
    input  logic [RD_DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_RD_LATENCY - 1);

    arb_state_t             state_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       gnt_q;
    logic [LAT_CNT_W-1:0]   cnt_q;
    logic [NUM_ACC-1:0]     rd_valid_q;
    logic [NUM_ACC-1:0]     wr_done_q;
    logic [RD_DATA_W-1:0]   rd_data_q;

    logic [NUM_ACC-1:0]     pend;
    logic [NUM_ACC-1:0]     grant_oh;
    logic [NUM_ACC-1:0]     gnt_oh_q;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic                   grant_vld;
    logic                   issue;
    logic                   sel_rd;

    assign pend = acc_rd_en | acc_wr_en;

    rr_picker #(
        .N     (NUM_ACC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i         (pend),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_vld),
        .grant_oh_o    (grant_oh),
        .grant_idx_o   (grant_idx)
    );

    // Gated by rst_n so nothing reaches memory while reset is held.
    assign issue    = rst_n && (state_q == ST_IDLE) && !cpu_busy && grant_vld;
    // A grantee asking for both is served as a read; its write waits.
    assign sel_rd   = acc_rd_en[grant_idx];
    assign rr_ptr_d = (grant_idx == IDX_W'(NUM_ACC - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign gnt_oh_q = NUM_ACC'(1) << gnt_q;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue) begin
            mem_en = 1'b1;
            if (sel_rd) begin
                mem_addr = acc_rd_addr[grant_idx*ADDR_W +: ADDR_W];
            end else begin
                mem_we    = 1'b1;
                mem_addr  = acc_wr_addr[grant_idx*ADDR_W +: ADDR_W];
                mem_wdata = acc_wr_data[grant_idx*WR_DATA_W +: WR_DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= '0;
            wr_done_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= '0;
            wr_done_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        gnt_q    <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        if (sel_rd) begin
                            cnt_q   <= LAT_LOAD;
                            state_q <= ST_RD_WAIT;
                        end else begin
                            wr_done_q <= grant_oh;
                            state_q   <= ST_WR_RESP;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // cnt_q == 0 marks the cycle the line is on mem_rdata.
                    if (cnt_q == '0) begin
                        rd_data_q  <= mem_rdata;
                        rd_valid_q <= gnt_oh_q;
                        state_q    <= ST_RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - LAT_CNT_W'(1);
                    end
                end
                ST_RD_RESP: state_q <= ST_IDLE;
                ST_WR_RESP: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign acc_rd_valid = rd_valid_q;
    assign acc_wr_done  = wr_done_q;
    assign acc_rd_data  = rd_data_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_acc_mem_arbiter
// Directed bench for acc_mem_arbiter. Two instances share the stimulus: one
// with read latency 1 and one with read latency 3. A small pipelined memory
// model per instance returns a known line for the issued address exactly
// MEM_RD_LATENCY cycles after mem_en and a junk pattern in every other cycle.
// -----------------------------------------------------------------------------
module tb_acc_mem_arbiter;

    localparam logic [511:0] JUNK = {64{8'hEE}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_busy;
    logic [1:0]   rd_en;
    logic [31:0]  rd_addr;
    logic [1:0]   wr_en;
    logic [31:0]  wr_addr;
    logic [63:0]  wr_data;

    logic [1:0]   o1_rd_valid, o1_wr_done, o3_rd_valid, o3_wr_done;
    logic [511:0] o1_rd_data, o3_rd_data;
    logic         o1_mem_en, o1_mem_we, o3_mem_en, o3_mem_we;
    logic [15:0]  o1_mem_addr, o3_mem_addr;
    logic [31:0]  o1_mem_wdata, o3_mem_wdata;
    logic [511:0] rdata1 = '0;
    logic [511:0] p3 [3];
    logic [511:0] rdata3;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    acc_mem_arbiter #(.NUM_ACC(2), .MEM_RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cpu_busy(cpu_busy),
        .acc_rd_en(rd_en), .acc_rd_addr(rd_addr),
        .acc_wr_en(wr_en), .acc_wr_addr(wr_addr), .acc_wr_data(wr_data),
        .acc_rd_valid(o1_rd_valid), .acc_rd_data(o1_rd_data), .acc_wr_done(o1_wr_done),
        .mem_en(o1_mem_en), .mem_we(o1_mem_we), .mem_addr(o1_mem_addr),
        .mem_wdata(o1_mem_wdata), .mem_rdata(rdata1)
    );

    acc_mem_arbiter #(.NUM_ACC(2), .MEM_RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cpu_busy(cpu_busy),
        .acc_rd_en(rd_en), .acc_rd_addr(rd_addr),
        .acc_wr_en(wr_en), .acc_wr_addr(wr_addr), .acc_wr_data(wr_data),
        .acc_rd_valid(o3_rd_valid), .acc_rd_data(o3_rd_data), .acc_wr_done(o3_wr_done),
        .mem_en(o3_mem_en), .mem_we(o3_mem_we), .mem_addr(o3_mem_addr),
        .mem_wdata(o3_mem_wdata), .mem_rdata(rdata3)
    );

    function automatic logic [511:0] line_of(input logic [15:0] a);
        if (a == 16'h1000) return {64{8'hA5}};
        return {32{a}};
    endfunction

    always @(posedge clk) begin
        rdata1 <= (o1_mem_en && !o1_mem_we) ? line_of(o1_mem_addr) : JUNK;
        p3[0]  <= (o3_mem_en && !o3_mem_we) ? line_of(o3_mem_addr) : JUNK;
        p3[1]  <= p3[0];
        p3[2]  <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cpu_busy = 1'b0;
        rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; cpu_busy = 1'b0;
        rd_en = 2'b01; rd_addr = 32'h0000_1000; wr_en = 2'b10; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_rd_valid, o1_wr_done} !== '0) begin
            err++;
            $display("FAIL reset_ctl1: got en=%0b we=%0b addr=%h wd=%h v=%b d=%b want all 0",
                     o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_rd_valid, o1_wr_done);
        end
        vec++;
        if (o1_rd_data !== '0) begin
            err++; $display("FAIL reset_data1: got %h want 0", o1_rd_data);
        end
        vec++;
        if ({o3_mem_en, o3_mem_addr, o3_rd_valid, o3_wr_done, o3_rd_data} !== '0) begin
            err++; $display("FAIL reset_dut3: got en=%0b addr=%h want all 0", o3_mem_en, o3_mem_addr);
        end
        rd_en = '0; wr_en = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        do_reset();
        @(negedge clk);
        rd_en = 2'b01; rd_addr = 32'h0000_1000;
        #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr} !== {1'b1, 1'b0, 16'h1000}) begin
            err++; $display("FAIL read_grant: got en=%0b we=%0b addr=%h want 1 0 1000", o1_mem_en, o1_mem_we, o1_mem_addr);
        end
        @(negedge clk); #1;
        vec++;
        if ({o1_rd_valid, o1_mem_en} !== 3'b000) begin
            err++; $display("FAIL read_wait: got v=%b en=%0b want 00 0", o1_rd_valid, o1_mem_en);
        end
        @(negedge clk); #1;
        vec++;
        if (o1_rd_valid !== 2'b01) begin
            err++; $display("FAIL read_valid: got %b want 01", o1_rd_valid);
        end
        vec++;
        if (o1_rd_data !== {64{8'hA5}}) begin
            err++; $display("FAIL read_data: got %h want a5..", o1_rd_data);
        end
        rd_en = '0;
        @(negedge clk); #1;
        vec++;
        if ({o1_rd_valid, o1_mem_en} !== 3'b000 || o1_rd_data !== {64{8'hA5}}) begin
            err++; $display("FAIL read_hold: got v=%b en=%0b data=%h want 00 0 a5..", o1_rd_valid, o1_mem_en, o1_rd_data);
        end
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        wr_en = 2'b10; wr_addr = {16'h5000, 16'h0000}; wr_data = {32'h0000_0005, 32'h0};
        #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_wr_done} !==
            {1'b1, 1'b1, 16'h5000, 32'h0000_0005, 2'b00}) begin
            err++; $display("FAIL write_grant: got en=%0b we=%0b addr=%h wd=%h done=%b want 1 1 5000 00000005 00",
                            o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_wr_done);
        end
        @(negedge clk); #1;
        vec++;
        if ({o1_wr_done, o1_mem_en} !== 3'b100) begin
            err++; $display("FAIL write_done: got done=%b en=%0b want 10 0", o1_wr_done, o1_mem_en);
        end
        wr_en = '0;
        @(negedge clk); #1;
        vec++;
        if (o1_wr_done !== 2'b00) begin
            err++; $display("FAIL write_pulse: got %b want 00", o1_wr_done);
        end
    endtask

    task automatic test_contention();
        logic        exp_en;
        logic [15:0] exp_addr;
        logic [1:0]  exp_v;
        int          g;
        do_reset();
        @(negedge clk);
        rd_addr = {16'h3000, 16'h2000}; rd_en = 2'b11;
        for (int c = 0; c < 12; c++) begin
            #1;
            g        = (c / 3) % 2;
            exp_en   = (c % 3 == 0);
            exp_addr = exp_en ? ((g == 1) ? 16'h3000 : 16'h2000) : 16'h0000;
            exp_v    = (c % 3 == 2) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
            vec++;
            if ({o1_mem_en, o1_mem_addr, o1_rd_valid} !== {exp_en, exp_addr, exp_v}) begin
                err++; $display("FAIL contention_c%0d: got en=%0b addr=%h v=%b want %0b %h %b",
                                c, o1_mem_en, o1_mem_addr, o1_rd_valid, exp_en, exp_addr, exp_v);
            end
            if (c % 3 == 2) begin
                vec++;
                if (o1_rd_data !== line_of((g == 1) ? 16'h3000 : 16'h2000)) begin
                    err++; $display("FAIL contention_data_c%0d: got %h", c, o1_rd_data);
                end
            end
            @(negedge clk);
        end
        rd_en = '0;
    endtask

    task automatic test_cpu_priority();
        do_reset();
        @(negedge clk);
        cpu_busy = 1'b1; rd_en = 2'b01; rd_addr = 32'h0000_1234;
        for (int i = 0; i < 10; i++) begin
            #1;
            vec++;
            if (o1_mem_en !== 1'b0) begin
                err++; $display("FAIL cpu_block_%0d: got en=%0b want 0", i, o1_mem_en);
            end
            @(negedge clk);
        end
        cpu_busy = 1'b0;
        #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
            err++; $display("FAIL cpu_release: got en=%0b we=%0b addr=%h want 1 0 1234", o1_mem_en, o1_mem_we, o1_mem_addr);
        end
        @(negedge clk);
        cpu_busy = 1'b1;
        #1;
        vec++;
        if ({o1_mem_en, o1_rd_valid} !== 3'b000) begin
            err++; $display("FAIL cpu_inflight: got en=%0b v=%b want 0 00", o1_mem_en, o1_rd_valid);
        end
        @(negedge clk); #1;
        vec++;
        if (o1_rd_valid !== 2'b01 || o1_rd_data !== line_of(16'h1234)) begin
            err++; $display("FAIL cpu_inflight_data: got v=%b data=%h want 01 line(1234)", o1_rd_valid, o1_rd_data);
        end
        rd_en = '0; cpu_busy = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        @(negedge clk);
        rd_en = 2'b01; rd_addr = 32'h0000_1040;
        #1;
        vec++;
        if ({o3_mem_en, o3_mem_we, o3_mem_addr} !== {1'b1, 1'b0, 16'h1040}) begin
            err++; $display("FAIL lat_grant: got en=%0b we=%0b addr=%h want 1 0 1040", o3_mem_en, o3_mem_we, o3_mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            vec++;
            if ({o3_rd_valid, o3_mem_en} !== 3'b000) begin
                err++; $display("FAIL lat_wait_T%0d: got v=%b en=%0b want 00 0", k, o3_rd_valid, o3_mem_en);
            end
        end
        @(negedge clk); #1;
        vec++;
        if (o3_rd_valid !== 2'b01 || o3_rd_data !== line_of(16'h1040)) begin
            err++; $display("FAIL lat_valid: got v=%b data=%h want 01 line(1040)", o3_rd_valid, o3_rd_data);
        end
        rd_en = '0;
        @(negedge clk); #1;
        vec++;
        if (o3_rd_valid !== 2'b00) begin
            err++; $display("FAIL lat_pulse: got %b want 00", o3_rd_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        rd_en = 2'b01; rd_addr = 32'h0000_1111;
        #1;
        vec++;
        if (o1_mem_en !== 1'b1) begin
            err++; $display("FAIL midrst_grant: got en=%0b want 1", o1_mem_en);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({o1_mem_en, o1_rd_valid} !== 3'b000) begin
            err++; $display("FAIL midrst_assert: got en=%0b v=%b want 0 00", o1_mem_en, o1_rd_valid);
        end
        @(negedge clk); #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_rd_valid, o1_wr_done} !== '0 ||
            o1_rd_data !== '0) begin
            err++; $display("FAIL midrst_outputs: got en=%0b v=%b data=%h want all 0", o1_mem_en, o1_rd_valid, o1_rd_data);
        end
        rst_n = 1'b1;
        wr_en = 2'b10; wr_addr = {16'h5004, 16'h0000}; wr_data = {32'hDEAD_BEEF, 32'h0};
        #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr} !== {1'b1, 1'b0, 16'h1111}) begin
            err++; $display("FAIL midrst_rrptr: got en=%0b we=%0b addr=%h want 1 0 1111", o1_mem_en, o1_mem_we, o1_mem_addr);
        end
        @(negedge clk);
        @(negedge clk); #1;
        vec++;
        if (o1_rd_valid !== 2'b01 || o1_rd_data !== line_of(16'h1111)) begin
            err++; $display("FAIL midrst_read: got v=%b data=%h want 01 line(1111)", o1_rd_valid, o1_rd_data);
        end
        rd_en = '0;
        @(negedge clk); #1;
        vec++;
        if ({o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_wr_done} !==
            {1'b1, 1'b1, 16'h5004, 32'hDEAD_BEEF, 2'b00}) begin
            err++; $display("FAIL midrst_wgrant: got en=%0b we=%0b addr=%h wd=%h done=%b want 1 1 5004 deadbeef 00",
                            o1_mem_en, o1_mem_we, o1_mem_addr, o1_mem_wdata, o1_wr_done);
        end
        @(negedge clk); #1;
        vec++;
        if (o1_wr_done !== 2'b10) begin
            err++; $display("FAIL midrst_wdone: got %b want 10", o1_wr_done);
        end
        wr_en = '0;
        @(negedge clk); #1;
        vec++;
        if (o1_wr_done !== 2'b00 || o1_rd_data !== line_of(16'h1111)) begin
            err++; $display("FAIL midrst_after: got done=%b data=%h want 00 line(1111)", o1_wr_done, o1_rd_data);
        end
    endtask

    initial begin
        rst_n = 1'b0; cpu_busy = 1'b0;
        rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_cpu_priority();
        test_latency();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
